// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes the EX/MEM control word, runs a req/ack data-memory
// access (word/byte, load/store) and hands registered results to the MEM/WB buffer.
module mem_stage_ctrl #(
    parameter int S       = 15,
    parameter int TIMEOUT = 8,
    parameter int CW      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [S:0]   in_upper,
    input  logic [S:0]   in_lower,
    input  logic [S:0]   in_word,
    input  logic [7:0]   in_byte,
    input  logic [S:0]   in_ctrl,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [S:0]   mem_addr,
    output logic [S:0]   mem_wdata,
    output logic [1:0]   mem_be,
    input  logic         mem_ack,
    input  logic [S:0]   mem_rdata,
    output logic [S:0]   out_result,
    output logic [S:0]   out_upper,
    output logic [S:0]   out_ctrl,
    output logic         out_valid,
    output logic         fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [S:0]    cap_upper_q, cap_upper_d;
    logic [S:0]    cap_ctrl_q, cap_ctrl_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [S:0]    mem_addr_q, mem_addr_d;
    logic [S:0]    mem_wdata_q, mem_wdata_d;
    logic [1:0]    mem_be_q, mem_be_d;
    logic [S:0]    out_result_q, out_result_d;
    logic [S:0]    out_upper_q, out_upper_d;
    logic [S:0]    out_ctrl_q, out_ctrl_d;
    logic          out_valid_q, out_valid_d;
    logic          fault_q, fault_d;

    logic          is_mem;
    logic          misaligned;
    logic [7:0]    sel_byte;
    logic [S:0]    load_result;
    logic [S:0]    in_ctrl_nowb;
    logic [S:0]    cap_ctrl_nowb;

    assign is_mem     = in_ctrl[5] & (in_ctrl[0] | in_ctrl[1]);
    assign misaligned = ~in_ctrl[2] & in_lower[0];
    assign stall      = ((state_q == IDLE) & is_mem) | (state_q == ACCESS);

    // Byte lane follows the held address; stores retire their address as the result.
    assign sel_byte = mem_addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    always_comb begin
        load_result = mem_rdata;
        if (cap_ctrl_q[1]) begin
            load_result = mem_addr_q;
        end else if (cap_ctrl_q[2]) begin
            if (cap_ctrl_q[3]) begin
                load_result = {{(S-7){sel_byte[7]}}, sel_byte};
            end else begin
                load_result = {{(S-7){1'b0}}, sel_byte};
            end
        end
    end

    // Faulted instructions must not write the register file.
    always_comb begin
        in_ctrl_nowb     = in_ctrl;
        in_ctrl_nowb[4]  = 1'b0;
        cap_ctrl_nowb    = cap_ctrl_q;
        cap_ctrl_nowb[4] = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_upper_d  = cap_upper_q;
        cap_ctrl_d   = cap_ctrl_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        out_result_d = out_result_q;
        out_upper_d  = out_upper_q;
        out_ctrl_d   = out_ctrl_q;
        out_valid_d  = 1'b0;
        fault_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_ctrl[5] && !is_mem) begin
                    out_result_d = in_lower;
                    out_upper_d  = in_upper;
                    out_ctrl_d   = in_ctrl;
                    out_valid_d  = 1'b1;
                end else if (is_mem) begin
                    cap_upper_d = in_upper;
                    cap_ctrl_d  = in_ctrl;
                    mem_addr_d  = in_lower;
                    mem_we_d    = in_ctrl[1];
                    if (in_ctrl[2]) begin
                        mem_be_d    = in_lower[0] ? 2'b10 : 2'b01;
                        mem_wdata_d = (S+1)'({in_byte, in_byte});
                    end else begin
                        mem_be_d    = 2'b11;
                        mem_wdata_d = in_word;
                    end
                    if (misaligned) begin
                        out_result_d = '0;
                        out_upper_d  = in_upper;
                        out_ctrl_d   = in_ctrl_nowb;
                        out_valid_d  = 1'b1;
                        fault_d      = 1'b1;
                        state_d      = DONE;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = ACCESS;
                    end
                end
            end

            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // An ack arriving on the expiry edge still completes normally.
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    out_result_d = load_result;
                    out_upper_d  = cap_upper_q;
                    out_ctrl_d   = cap_ctrl_q;
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_req_d    = 1'b0;
                    out_result_d = '0;
                    out_upper_d  = cap_upper_q;
                    out_ctrl_d   = cap_ctrl_nowb;
                    out_valid_d  = 1'b1;
                    fault_d      = 1'b1;
                    state_d      = DONE;
                end
            end

            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_upper_q  <= '0;
            cap_ctrl_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= 2'b00;
            out_result_q <= '0;
            out_upper_q  <= '0;
            out_ctrl_q   <= '0;
            out_valid_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_upper_q  <= cap_upper_d;
            cap_ctrl_q   <= cap_ctrl_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            out_result_q <= out_result_d;
            out_upper_q  <= out_upper_d;
            out_ctrl_q   <= out_ctrl_d;
            out_valid_q  <= out_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign out_result = out_result_q;
    assign out_upper  = out_upper_q;
    assign out_ctrl   = out_ctrl_q;
    assign out_valid  = out_valid_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-op expected timeline derived from the
// instruction's meaning, checked every cycle, plus hand-computed literal results.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic [15:0] in_upper, in_lower, in_word, in_ctrl;
    logic [7:0]  in_byte;
    logic        stall, mem_req, mem_we, mem_ack, out_valid, fault;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, out_result, out_upper, out_ctrl;
    logic [1:0]  mem_be;

    mem_stage_ctrl #(.S(15), .TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .in_upper(in_upper), .in_lower(in_lower), .in_word(in_word),
        .in_byte(in_byte), .in_ctrl(in_ctrl),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_result(out_result), .out_upper(out_upper), .out_ctrl(out_ctrl),
        .out_valid(out_valid), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ctrl, lower, upper, word;
        logic [7:0]  byt;
        logic [15:0] rdata;
        int          ack_at;      // ACCESS cycle (1-based) carrying ack; 0 = never
        bit          ack_early;   // also pulse ack in the IDLE and DONE cycles
        logic [15:0] lit_result;
        int          lit_stalls;
    } op_t;

    int checks   = 0;
    int failures = 0;
    int chk_mode = 0;   // 0 idle, 1 op timeline, 2 reset state
    int stall_cnt = 0;
    int lit_stalls = 0;
    bit exp_stall, exp_req, exp_we, exp_valid, exp_fault, exp_first, exp_last;
    logic [15:0] exp_addr, exp_wdata, exp_result, exp_upper, exp_ctrl, lit_result;
    logic [1:0]  exp_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_mode == 1) begin
                if (exp_first) stall_cnt = 0;
                if (stall) stall_cnt++;
                chk("stall", stall, exp_stall);
                chk("mem_req", mem_req, exp_req);
                chk("out_valid", out_valid, exp_valid);
                chk("fault", fault, exp_fault);
                if (exp_req) begin
                    chk("mem_we", mem_we, exp_we);
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_wdata", mem_wdata, exp_wdata);
                    chk("mem_be", mem_be, exp_be);
                end
                if (exp_valid) begin
                    chk("out_result", out_result, exp_result);
                    chk("out_upper", out_upper, exp_upper);
                    chk("out_ctrl", out_ctrl, exp_ctrl);
                    chk("lit_result", out_result, lit_result);
                end
                if (exp_last) chk("lit_stalls", stall_cnt, lit_stalls);
            end else if (chk_mode == 2) begin
                chk("rst_stall", stall, exp_stall);
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_be", mem_be, 0);
                chk("rst_out_result", out_result, 0);
                chk("rst_out_upper", out_upper, 0);
                chk("rst_out_ctrl", out_ctrl, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_fault", fault, 0);
            end
        end
    end

    function automatic op_t mk(input logic [15:0] ctrl, lower, upper, word,
                               input logic [7:0] byt, input logic [15:0] rdata,
                               input int ack_at, input bit early,
                               input logic [15:0] lit, input int stalls);
        op_t o;
        o.ctrl = ctrl; o.lower = lower; o.upper = upper; o.word = word;
        o.byt = byt; o.rdata = rdata; o.ack_at = ack_at; o.ack_early = early;
        o.lit_result = lit; o.lit_stalls = stalls;
        return o;
    endfunction

    task automatic drive_bubble();
        in_ctrl = 16'h0000; in_lower = 16'h0000; in_upper = 16'h0000;
        in_word = 16'h0000; in_byte = 8'h00;
    endtask

    task automatic run_op(input op_t op);
        bit mem, mis, to, wr;
        int len, last;
        logic [7:0]  b;
        logic [15:0] res, octl;
        mem = op.ctrl[5] && (op.ctrl[0] || op.ctrl[1]);
        mis = mem && !op.ctrl[2] && op.lower[0];
        wr  = op.ctrl[1];
        to  = mem && !mis && (op.ack_at == 0);
        len  = (!mem || mis) ? 0 : (to ? TIMEOUT : op.ack_at);
        last = !op.ctrl[5] ? 0 : (mem ? len + 1 : 1);
        b = op.lower[0] ? op.rdata[15:8] : op.rdata[7:0];
        if (!mem)            res = op.lower;
        else if (mis || to)  res = 16'h0000;
        else if (wr)         res = op.lower;
        else if (op.ctrl[2]) res = op.ctrl[3] ? {{8{b[7]}}, b} : {8'h00, b};
        else                 res = op.rdata;
        octl = op.ctrl;
        if (mis || to) octl[4] = 1'b0;

        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 0 || mem) begin
                in_ctrl = op.ctrl; in_lower = op.lower; in_upper = op.upper;
                in_word = op.word; in_byte = op.byt;
            end else begin
                drive_bubble();
            end
            mem_ack   = (mem && !mis && !to && c == len) || (op.ack_early && (c == 0 || c == last));
            mem_rdata = (mem && c == len) ? op.rdata : ~op.rdata;
            exp_stall  = mem && (c <= len);
            exp_req    = mem && !mis && (c >= 1) && (c <= len);
            exp_we     = wr;
            exp_addr   = op.lower;
            exp_be     = op.ctrl[2] ? (op.lower[0] ? 2'b10 : 2'b01) : 2'b11;
            exp_wdata  = op.ctrl[2] ? {op.byt, op.byt} : op.word;
            exp_valid  = op.ctrl[5] && (c == last);
            exp_fault  = exp_valid && (mis || to);
            exp_result = res;
            exp_upper  = op.upper;
            exp_ctrl   = octl;
            exp_first  = (c == 0);
            exp_last   = (c == last);
            lit_result = op.lit_result;
            lit_stalls = op.lit_stalls;
            chk_mode   = 1;
            @(negedge clk);
        end
        $display("op ctrl=%h addr=%h cycles=%0d exp_result=%h fault=%0d",
                 op.ctrl, op.lower, last + 1, res, mis || to);
    endtask

    op_t ops[$];

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
        drive_bubble();
        exp_stall = 1'b0;
        @(posedge clk); #1;
        chk_mode = 2;
        @(negedge clk);
        @(posedge clk); #1;
        chk_mode = 0;
        rst = 1'b1;

        //            ctrl      lower     upper     word      byte   rdata     ack ea  literal   stalls
        ops.push_back(mk(16'h0030, 16'h1234, 16'h5678, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h1234, 0));
        ops.push_back(mk(16'h0031, 16'h0040, 16'h0A0A, 16'h0000, 8'h00, 16'hBEEF, 3, 0, 16'hBEEF, 4));
        ops.push_back(mk(16'h003D, 16'h0041, 16'h0B0B, 16'h0000, 8'h00, 16'h80FF, 2, 0, 16'hFF80, 3));
        ops.push_back(mk(16'h0035, 16'h0041, 16'h0C0C, 16'h0000, 8'h00, 16'h80FF, 1, 1, 16'h0080, 2));
        ops.push_back(mk(16'h0026, 16'h0010, 16'h0D0D, 16'h0000, 8'hA5, 16'h0000, 2, 0, 16'h0010, 3));
        ops.push_back(mk(16'h0032, 16'h0003, 16'h0E0E, 16'h1111, 8'h00, 16'h0000, 0, 0, 16'h0000, 1));
        ops.push_back(mk(16'h0000, 16'h9999, 16'h0000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0000, 0));
        ops.push_back(mk(16'h0011, 16'h0040, 16'h0000, 16'h0000, 8'h00, 16'h0000, 0, 1, 16'h0000, 0));
        ops.push_back(mk(16'h0031, 16'h0080, 16'h0F0F, 16'h0000, 8'h00, 16'h4321, 0, 0, 16'h0000, 9));
        ops.push_back(mk(16'h0031, 16'h0082, 16'h1010, 16'h0000, 8'h00, 16'h1357, TIMEOUT, 0, 16'h1357, 9));
        ops.push_back(mk(16'h0033, 16'h0020, 16'h2020, 16'hCAFE, 8'h00, 16'h0000, 1, 0, 16'h0020, 2));
        ops.push_back(mk(16'h003D, 16'h0042, 16'h3030, 16'h0000, 8'h00, 16'h7F80, 1, 0, 16'hFF80, 2));
        ops.push_back(mk(16'h0031, 16'h0005, 16'h4040, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0000, 1));
        ops.push_back(mk(16'hAB30, 16'h0F0F, 16'h5050, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0F0F, 0));
        ops.push_back(mk(16'h0026, 16'h0011, 16'h6060, 16'h0000, 8'h3C, 16'h0000, 1, 0, 16'h0011, 2));

        foreach (ops[i]) run_op(ops[i]);

        // Reset pulled low mid-ACCESS, between clock edges.
        @(posedge clk); #1;
        chk_mode = 0;
        in_ctrl = 16'h0031; in_lower = 16'h0060; in_upper = 16'h7070;
        mem_ack = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b0;
        exp_stall = 1'b1;
        chk_mode = 2;
        @(negedge clk);
        @(posedge clk); #1;
        chk_mode = 0;
        drive_bubble();
        @(posedge clk); #1;
        rst = 1'b1;
        $display("reset applied mid-access");

        run_op(mk(16'h0031, 16'h0044, 16'h8080, 16'h0000, 8'h00, 16'h2468, 2, 0, 16'h2468, 3));
        run_op(mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0000, 0));

        chk_mode = 0;
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
